// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit:
// FSM states, instruction classes, ALU opcodes, write-back selects and trap causes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StTrap
    } ctrl_state_e;

    typedef enum logic [3:0] {
        ClsIllegal,
        ClsRAlu,
        ClsIAlu,
        ClsLui,
        ClsAuipc,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsJal,
        ClsJalr
    } instr_cls_e;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluSll  = 4'b0010;
    localparam logic [3:0] AluSlt  = 4'b0011;
    localparam logic [3:0] AluSltu = 4'b0100;
    localparam logic [3:0] AluXor  = 4'b0101;
    localparam logic [3:0] AluSra  = 4'b0110;
    localparam logic [3:0] AluSrl  = 4'b0111;
    localparam logic [3:0] AluOr   = 4'b1000;
    localparam logic [3:0] AluAnd  = 4'b1001;

    localparam logic [1:0] WbAlu  = 2'b00;
    localparam logic [1:0] WbRsvd = 2'b01;
    localparam logic [1:0] WbPc   = 2'b10;
    localparam logic [1:0] WbLoad = 2'b11;

    localparam logic [1:0] CauseNone     = 2'b00;
    localparam logic [1:0] CauseIllegal  = 2'b01;
    localparam logic [1:0] CauseMisalign = 2'b10;
    localparam logic [1:0] CauseTimeout  = 2'b11;

    // alt selects SUB/SRA (instr bit 30) where the funct3 allows it.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier: instr -> class, ALU opcode, unsigned-compare flag
// and illegal flag.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned ALU_OP_W = 4
) (
    input  logic [31:0]         i_instr,
    output instr_cls_e          o_cls,
    output logic [ALU_OP_W-1:0] o_alu_opcode,
    output logic                o_br_unsign,
    output logic                o_illegal
);

    logic [6:0] w_opcode;
    logic [6:0] w_funct7;
    logic [2:0] w_funct3;
    logic [3:0] w_alu;
    logic       w_r_funct7_ok;
    logic       w_unused;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

    // R-type only defines funct7 = 0, plus 0100000 for SUB and SRA.
    assign w_r_funct7_ok = (w_funct7 == 7'b0000000) ||
                           ((w_funct7 == 7'b0100000) &&
                            ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));

    always_comb begin
        o_cls       = ClsIllegal;
        w_alu       = AluAdd;
        o_br_unsign = 1'b0;
        case (w_opcode)
            OpcOp: begin
                o_cls       = w_r_funct7_ok ? ClsRAlu : ClsIllegal;
                w_alu       = alu_from_funct3(w_funct3, w_funct7[5]);
                o_br_unsign = (w_funct3 == 3'b011);
            end
            OpcOpImm: begin
                o_cls       = ClsIAlu;
                w_alu       = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
                o_br_unsign = (w_funct3 == 3'b011);
            end
            OpcLui:   o_cls = ClsLui;
            OpcAuipc: o_cls = ClsAuipc;
            OpcLoad:  o_cls = ClsLoad;
            OpcStore: o_cls = ClsStore;
            OpcBranch: begin
                o_cls       = ClsBranch;
                o_br_unsign = (w_funct3[2:1] == 2'b11);
            end
            OpcJal:   o_cls = ClsJal;
            OpcJalr:  o_cls = ClsJalr;
            default:  o_cls = ClsIllegal;
        endcase
    end

    assign o_illegal    = (o_cls == ClsIllegal);
    assign o_alu_opcode = ALU_OP_W'(w_alu);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with memory watchdog and sticky trap state.
// Define MISALIGN_TRAP_EN to trap on misaligned load/store/jump targets in EXEC.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TMO_CYCLES = 16,
    parameter int unsigned ALU_OP_W       = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [31:0]         i_instr,
    input  logic                i_mem_ready,
    input  logic                i_br_taken,
    input  logic [1:0]          i_alu_lsb,
    output logic                o_pc_wren,
    output logic                o_ir_wren,
    output logic                o_pc_sel,
    output logic                o_op1_sel,
    output logic                o_op2_sel,
    output logic [ALU_OP_W-1:0] o_alu_opcode,
    output logic                o_br_unsign,
    output logic                o_rd_wren,
    output logic                o_mem_rden,
    output logic                o_mem_wren,
    output logic [1:0]          o_wb_sel,
    output logic                o_trap,
    output logic [1:0]          o_trap_cause
);

    localparam int unsigned CntW = (MEM_TMO_CYCLES > 0) ? $clog2(MEM_TMO_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast =
        (MEM_TMO_CYCLES > 0) ? CntW'(MEM_TMO_CYCLES - 1) : '0;

    ctrl_state_e         r_state;
    logic [CntW-1:0]     r_cnt;
    logic [1:0]          r_cause;

    instr_cls_e          w_cls;
    logic [ALU_OP_W-1:0] w_alu_op;
    logic                w_br_unsign;
    logic                w_illegal;
    logic                w_misalign;
    logic                w_mem_wait;
    logic                w_tmo;

    ctrl_decode #(
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .i_instr      (i_instr),
        .o_cls        (w_cls),
        .o_alu_opcode (w_alu_op),
        .o_br_unsign  (w_br_unsign),
        .o_illegal    (w_illegal)
    );

`ifdef MISALIGN_TRAP_EN
    logic [2:0] w_funct3;
    assign w_funct3 = i_instr[14:12];

    // funct3[1:0]: 10 = word, 01 = half (signed or unsigned), 00 = byte.
    always_comb begin
        w_misalign = 1'b0;
        if (r_state == StExec) begin
            case (w_cls)
                ClsLoad, ClsStore: begin
                    if (w_funct3[1:0] == 2'b10)      w_misalign = |i_alu_lsb;
                    else if (w_funct3[1:0] == 2'b01) w_misalign = i_alu_lsb[0];
                end
                ClsJal, ClsJalr: w_misalign = i_alu_lsb[1];
                ClsBranch:       w_misalign = i_br_taken & i_alu_lsb[1];
                default:         w_misalign = 1'b0;
            endcase
        end
    end
`else
    logic w_unused_lsb;
    assign w_unused_lsb = ^i_alu_lsb;
    assign w_misalign   = 1'b0;
`endif

    assign w_mem_wait = ((r_state == StFetch) || (r_state == StMem)) && !i_mem_ready;
    // A ready in the limit cycle wins because w_mem_wait is already low then.
    assign w_tmo = (MEM_TMO_CYCLES != 0) && w_mem_wait && (r_cnt == CntLast);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_cause <= CauseNone;
        end else begin
            case (r_state)
                StIdle: begin
                    r_state <= StFetch;
                    r_cnt   <= '0;
                end
                StFetch: begin
                    if (i_mem_ready) begin
                        r_state <= StDecode;
                    end else if (w_tmo) begin
                        r_state <= StTrap;
                        r_cause <= CauseTimeout;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StDecode: begin
                    if (w_illegal) begin
                        r_state <= StTrap;
                        r_cause <= CauseIllegal;
                    end else begin
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    if (w_misalign) begin
                        r_state <= StTrap;
                        r_cause <= CauseMisalign;
                    end else begin
                        case (w_cls)
                            ClsRAlu, ClsIAlu, ClsLui, ClsAuipc: r_state <= StWb;
                            ClsLoad, ClsStore: begin
                                r_state <= StMem;
                                r_cnt   <= '0;
                            end
                            default: begin
                                r_state <= StFetch;
                                r_cnt   <= '0;
                            end
                        endcase
                    end
                end
                StMem: begin
                    if (i_mem_ready) begin
                        r_state <= (w_cls == ClsLoad) ? StWb : StFetch;
                        r_cnt   <= '0;
                    end else if (w_tmo) begin
                        r_state <= StTrap;
                        r_cause <= CauseTimeout;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StWb: begin
                    r_state <= StFetch;
                    r_cnt   <= '0;
                end
                StTrap:  r_state <= StTrap;
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        o_pc_wren    = 1'b0;
        o_ir_wren    = 1'b0;
        o_pc_sel     = 1'b0;
        o_op1_sel    = 1'b0;
        o_op2_sel    = 1'b0;
        o_alu_opcode = '0;
        o_br_unsign  = 1'b0;
        o_rd_wren    = 1'b0;
        o_mem_rden   = 1'b0;
        o_mem_wren   = 1'b0;
        o_wb_sel     = WbAlu;
        o_trap       = 1'b0;
        o_trap_cause = r_cause;

        // ALU controls stay stable from EXEC through WB so MEM address and WB result hold.
        // LUI relies on the datapath forcing rs1 to x0 for that opcode.
        if ((r_state == StExec) || (r_state == StMem) || (r_state == StWb)) begin
            o_alu_opcode = w_alu_op;
            o_br_unsign  = w_br_unsign;
            o_op1_sel    = (w_cls == ClsAuipc) || (w_cls == ClsBranch) || (w_cls == ClsJal);
            o_op2_sel    = (w_cls != ClsRAlu);
        end

        case (r_state)
            StFetch: begin
                o_mem_rden = 1'b1;
                o_ir_wren  = i_mem_ready;
                o_pc_wren  = i_mem_ready;
            end
            StExec: begin
                if (!w_misalign) begin
                    case (w_cls)
                        ClsBranch: begin
                            o_pc_wren = i_br_taken;
                            o_pc_sel  = i_br_taken;
                        end
                        ClsJal, ClsJalr: begin
                            o_rd_wren = 1'b1;
                            o_wb_sel  = WbPc;
                            o_pc_wren = 1'b1;
                            o_pc_sel  = 1'b1;
                        end
                        default: o_pc_wren = 1'b0;
                    endcase
                end
            end
            StMem: begin
                o_mem_rden = (w_cls == ClsLoad);
                o_mem_wren = (w_cls == ClsStore);
            end
            StWb: begin
                o_rd_wren = 1'b1;
                o_wb_sel  = (w_cls == ClsLoad) ? WbLoad : WbAlu;
            end
            StTrap:  o_trap = 1'b1;
            default: o_trap = 1'b0;
        endcase
    end

endmodule
